// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential 8-by-4 divider.
// The master drives the operands and Start; the slave returns results and status.
interface seq_divider_if;
   logic       Start;
   logic [7:0] Dividend;
   logic [3:0] Divisor;
   logic [7:0] Quotient;
   logic [3:0] Remainder;
   logic       Busy;
   logic       Done;
   logic       DivByZero;

   modport master (
      output Start, Dividend, Divisor,
      input  Quotient, Remainder, Busy, Done, DivByZero
   );

   modport slave (
      input  Start, Dividend, Divisor,
      output Quotient, Remainder, Busy, Done, DivByZero
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor.
// It produces one quotient bit per clock, MSB first, and takes 8 iterations.
// A zero divisor bypasses the iterations and reports FF r0 with DivByZero set.
// Result registers change only when the FSM enters DONE, so they stay stable
// through IDLE and through the next CALC.
module seq_divider (
   input  logic        Clock,
   input  logic        Reset_b,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  dvd_q,   dvd_d;     // dividend shift register, MSB consumed first
   logic [3:0]  dvs_q,   dvs_d;     // latched divisor
   logic [3:0]  rem_q,   rem_d;     // restored remainder between iterations
   logic [7:0]  quo_q,   quo_d;     // quotient bits shifted in LSB-side
   logic [2:0]  cnt_q,   cnt_d;     // iteration index 0..7
   logic [7:0]  qout_q,  qout_d;    // published quotient
   logic [3:0]  rout_q,  rout_d;    // published remainder
   logic        dbz_q,   dbz_d;     // published divide-by-zero flag

   // 5-bit partial remainder for the current iteration
   logic [4:0]  part_rem;
   logic [4:0]  part_sub;
   logic        qbit;

   // One restoring step: shift in the next dividend bit, then trial-subtract.
   // The restored remainder is always below the divisor, so 4 stored bits
   // suffice; the widened 5-bit partial value absorbs the shift.
   always_comb begin
      part_rem = {rem_q, dvd_q[7]};
      if (part_rem >= {1'b0, dvs_q}) begin
         part_sub = part_rem - {1'b0, dvs_q};
         qbit     = 1'b1;
      end else begin
         part_sub = part_rem;
         qbit     = 1'b0;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      qout_d  = qout_q;
      rout_d  = rout_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               dvd_d = bus.Dividend;
               dvs_d = bus.Divisor;
               rem_d = '0;
               quo_d = '0;
               cnt_d = '0;
               if (bus.Divisor == '0) begin
                  state_d = DONE;
                  qout_d  = '1;
                  rout_d  = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  dbz_d   = 1'b0;
               end
            end
         end

         CALC: begin
            rem_d = 4'(part_sub);
            dvd_d = {dvd_q[6:0], 1'b0};
            quo_d = {quo_q[6:0], qbit};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
               qout_d  = {quo_q[6:0], qbit};
               rout_d  = 4'(part_sub);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         qout_q  <= '0;
         rout_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.Quotient  = qout_q;
   assign bus.Remainder = rout_q;
   assign bus.DivByZero = dbz_q;
   assign bus.Busy      = (state_q == CALC);
   assign bus.Done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: corner vectors, divide-by-zero, ignored
// restart, held Start, mid-operation reset and a full operand sweep.
module tb_seq_divider;

   logic        Clock = 1'b0;
   logic        Reset_b;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [7:0]  prev_q;
   logic [3:0]  prev_r;

   seq_divider_if bus ();

   seq_divider dut (
      .Clock   (Clock),
      .Reset_b (Reset_b),
      .bus     (bus)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er);
      int unsigned lat;
      int unsigned busy_n;
      int unsigned both_n;
      bus.Start    = 1'b1;
      bus.Dividend = a;
      bus.Divisor  = b;
      @(posedge Clock);
      @(negedge Clock);
      bus.Start    = 1'b0;
      bus.Dividend = ~a;
      bus.Divisor  = ~b;
      if (b != 4'd0) begin
         check_eq("hold_q", bus.Quotient, prev_q);
         check_eq("hold_r", bus.Remainder, prev_r);
      end
      lat    = 1;
      busy_n = 0;
      both_n = 0;
      while (bus.Done !== 1'b1 && lat < 20) begin
         if (bus.Busy === 1'b1) busy_n++;
         @(negedge Clock);
         lat++;
      end
      if (bus.Busy === 1'b1 && bus.Done === 1'b1) both_n++;
      check_eq("latency", lat, (b == 4'd0) ? 32'd1 : 32'd9);
      check_eq("busy_cycles", busy_n, (b == 4'd0) ? 32'd0 : 32'd8);
      check_eq("busy_and_done", both_n, 32'd0);
      check_eq("quotient", bus.Quotient, eq);
      check_eq("remainder", bus.Remainder, er);
      check_eq("divbyzero", bus.DivByZero, (b == 4'd0) ? 32'd1 : 32'd0);
      @(negedge Clock);
      check_eq("done_pulse_width", bus.Done, 32'd0);
      prev_q = eq;
      prev_r = er;
   endtask

   task automatic wait_done(output int unsigned t);
      bit found;
      found = 1'b0;
      t = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge Clock);
         if (bus.Done === 1'b1) begin
            found = 1'b1;
            t = cyc;
         end
      end
      if (!found) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   logic [7:0] vec_a [7] = '{8'd200, 8'd255, 8'd0, 8'd15, 8'd7,  8'd13,  8'd9};
   logic [3:0] vec_b [7] = '{4'd7,   4'd1,   4'd5, 4'd15, 4'd15, 4'd0,   4'd2};
   logic [7:0] vec_q [7] = '{8'd28,  8'd255, 8'd0, 8'd1,  8'd0,  8'hFF,  8'd4};
   logic [3:0] vec_r [7] = '{4'd4,   4'd0,   4'd0, 4'd0,  4'd7,  4'd0,   4'd1};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned t1, t2, t3, t4;
      int unsigned dones;
      logic [7:0] cq;
      logic [3:0] cr;
      bus.Start    = 1'b0;
      bus.Dividend = '0;
      bus.Divisor  = '0;
      Reset_b      = 1'b1;
      prev_q       = '0;
      prev_r       = '0;
      #2 Reset_b = 1'b0;
      #1;
      check_eq("rst_quotient", bus.Quotient, 32'd0);
      check_eq("rst_remainder", bus.Remainder, 32'd0);
      check_eq("rst_busy", bus.Busy, 32'd0);
      check_eq("rst_done", bus.Done, 32'd0);
      check_eq("rst_dbz", bus.DivByZero, 32'd0);
      repeat (2) @(negedge Clock);
      Reset_b = 1'b1;
      @(negedge Clock);

      // Directed vectors, including 13/0 followed by 9/2 clearing the flag
      for (int i = 0; i < 7; i++) run_div(vec_a[i], vec_b[i], vec_q[i], vec_r[i]);

      // Start held high: 9/2 back-to-back, then 0-divisor back-to-back
      bus.Start    = 1'b1;
      bus.Dividend = 8'd9;
      bus.Divisor  = 4'd2;
      wait_done(t1);
      wait_done(t2);
      check_eq("b2b_spacing", t2 - t1, 32'd10);
      check_eq("b2b_quotient", bus.Quotient, 32'd4);
      check_eq("b2b_remainder", bus.Remainder, 32'd1);
      bus.Divisor = 4'd0;
      wait_done(t3);
      wait_done(t4);
      bus.Start = 1'b0;
      check_eq("b2b_dbz_spacing", t4 - t3, 32'd2);
      check_eq("b2b_dbz_quotient", bus.Quotient, 32'hFF);
      check_eq("b2b_dbz_flag", bus.DivByZero, 32'd1);
      repeat (2) @(negedge Clock);

      // Start during CALC with different operands is ignored
      bus.Start    = 1'b1;
      bus.Dividend = 8'd100;
      bus.Divisor  = 4'd3;
      @(posedge Clock);
      @(negedge Clock);
      bus.Start = 1'b0;
      repeat (3) @(negedge Clock);
      bus.Start    = 1'b1;
      bus.Dividend = 8'd50;
      bus.Divisor  = 4'd5;
      dones = 0;
      @(negedge Clock);
      bus.Start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (bus.Done === 1'b1) dones++;
         @(negedge Clock);
      end
      cq = bus.Quotient;
      cr = bus.Remainder;
      check_eq("restart_done_count", dones, 32'd1);
      check_eq("restart_quotient", cq, 32'd33);
      check_eq("restart_remainder", cr, 32'd1);
      prev_q = 8'd33;
      prev_r = 4'd1;

      // Reset mid-CALC aborts the division with no Done pulse
      bus.Start    = 1'b1;
      bus.Dividend = 8'd200;
      bus.Divisor  = 4'd7;
      @(posedge Clock);
      @(negedge Clock);
      bus.Start = 1'b0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset_b = 1'b0;
      #1;
      check_eq("abort_quotient", bus.Quotient, 32'd0);
      check_eq("abort_remainder", bus.Remainder, 32'd0);
      check_eq("abort_busy", bus.Busy, 32'd0);
      check_eq("abort_done", bus.Done, 32'd0);
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         if (bus.Done === 1'b1) dones++;
      end
      check_eq("abort_done_count", dones, 32'd0);
      Reset_b = 1'b1;
      prev_q  = '0;
      prev_r  = '0;
      run_div(8'd9, 4'd4, 8'd2, 4'd1);

      // Full operand sweep against the reference divide
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) run_div(8'(a), 4'(b), 8'hFF, 4'd0);
            else        run_div(8'(a), 4'(b), 8'(a / b), 4'(a % b));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
